// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, branch/jump redirects
// and a one-entry pending-redirect buffer that holds a redirect seen while
// the PC is held.
// Optional feature macro: PC_UNIT_TRAP_EN adds a trap input (top priority)
// and an epc output.
module pc_unit #(
  parameter int unsigned  N        = 32,
  parameter int unsigned  STEP     = 1,
  parameter logic [N-1:0] RESET_PC = '0,
  parameter logic [N-1:0] TRAP_VEC = N'(32'h0000_0008)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         stall,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  input  logic         jmp,
  input  logic [N-1:0] jmp_target,
`ifdef PC_UNIT_TRAP_EN
  input  logic         trap,
  output logic [N-1:0] epc,
`endif
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus,
  output logic         pc_valid,
  output logic         redirect_pending
);

  logic [N-1:0] pc_d;
  logic         pc_valid_d;
  logic         pend_d;
  logic [N-1:0] pend_target;
  logic [N-1:0] pend_target_d;
  logic         hold;
  logic         redirect;
  logic [N-1:0] redirect_target;

  // Sequential successor, wraps modulo 2^N
  assign pc_plus = pc + N'(STEP);

  // The warm-up cycle behaves like a stall so early redirects are buffered
  assign hold            = stall || !pc_valid;
  assign redirect        = jmp || br_taken;
  assign redirect_target = jmp ? jmp_target : br_target;

`ifdef PC_UNIT_TRAP_EN
  logic [N-1:0] epc_d;
`else
  logic unused_trap_vec;
  assign unused_trap_vec = ^TRAP_VEC;
`endif

  // Next-state selection: trap > hold/buffer > jmp > branch > pending > step
  always_comb begin
    pc_d          = pc;
    pc_valid_d    = 1'b1;
    pend_d        = redirect_pending;
    pend_target_d = pend_target;
`ifdef PC_UNIT_TRAP_EN
    epc_d         = epc;
`endif
    if (hold) begin
      if (redirect) begin
        pend_d        = 1'b1;
        pend_target_d = redirect_target;
      end
    end else begin
      pend_d = 1'b0;
      if (redirect) begin
        pc_d = redirect_target;
      end else if (redirect_pending) begin
        pc_d = pend_target;
      end else begin
        pc_d = pc_plus;
      end
    end
`ifdef PC_UNIT_TRAP_EN
    if (trap) begin
      pc_d   = TRAP_VEC;
      epc_d  = pc;
      pend_d = 1'b0;
    end
`endif
  end

  // State registers, cleared immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc               <= RESET_PC;
      pc_valid         <= 1'b0;
      redirect_pending <= 1'b0;
      pend_target      <= '0;
`ifdef PC_UNIT_TRAP_EN
      epc              <= '0;
`endif
    end else begin
      pc               <= pc_d;
      pc_valid         <= pc_valid_d;
      redirect_pending <= pend_d;
      pend_target      <= pend_target_d;
`ifdef PC_UNIT_TRAP_EN
      epc              <= epc_d;
`endif
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Testbench for pc_unit: directed vector table, hand-written corner
// sequences and randomized stimulus against a behavioural model. Two
// instances run in lockstep: STEP=1 and STEP=4.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic        jmp = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] br_target = '0;
  logic [31:0] jmp_target = '0;

  logic [31:0] pc1, plus1, pc4, plus4;
  logic        v1, p1, v4, p4;
`ifdef PC_UNIT_TRAP_EN
  logic [31:0] epc1, epc4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit #(.N(32), .STEP(1), .RESET_PC(32'h0)) dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
`ifdef PC_UNIT_TRAP_EN
    .trap(trap), .epc(epc1),
`endif
    .pc(pc1), .pc_plus(plus1), .pc_valid(v1), .redirect_pending(p1)
  );

  pc_unit #(.N(32), .STEP(4), .RESET_PC(32'h0)) dut4 (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .jmp_target(jmp_target),
`ifdef PC_UNIT_TRAP_EN
    .trap(trap), .epc(epc4),
`endif
    .pc(pc4), .pc_plus(plus4), .pc_valid(v4), .redirect_pending(p4)
  );

  // Behavioural model of the fetch address stream
  typedef struct {
    logic [31:0] pc;
    bit          v;
    bit          p;
    logic [31:0] t;
    logic [31:0] epc;
  } mst_t;

  mst_t m1, m4;

  function automatic mst_t mreset();
    mst_t s;
    s.pc = 32'h0; s.v = 1'b0; s.p = 1'b0; s.t = 32'h0; s.epc = 32'h0;
    return s;
  endfunction

  function automatic mst_t mnext(mst_t s, int unsigned step);
    mst_t n = s;
    n.v = 1'b1;
    if (trap) begin
      n.epc = s.pc;
      n.pc  = 32'h8;
      n.p   = 1'b0;
    end else if (stall || !s.v) begin
      if (jmp) begin
        n.t = jmp_target; n.p = 1'b1;
      end else if (br_taken) begin
        n.t = br_target; n.p = 1'b1;
      end
    end else begin
      n.p = 1'b0;
      if (jmp)           n.pc = jmp_target;
      else if (br_taken) n.pc = br_target;
      else if (s.p)      n.pc = s.t;
      else               n.pc = 32'(s.pc + 32'(step));
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag);
    chk({tag, ".pc1"}, pc1, m1.pc);
    chk({tag, ".plus1"}, plus1, 32'(m1.pc + 32'd1));
    chkb({tag, ".valid1"}, v1, m1.v);
    chkb({tag, ".pend1"}, p1, m1.p);
    chk({tag, ".pc4"}, pc4, m4.pc);
    chk({tag, ".plus4"}, plus4, 32'(m4.pc + 32'd4));
    chkb({tag, ".valid4"}, v4, m4.v);
    chkb({tag, ".pend4"}, p4, m4.p);
`ifdef PC_UNIT_TRAP_EN
    chk({tag, ".epc1"}, epc1, m1.epc);
    chk({tag, ".epc4"}, epc4, m4.epc);
`endif
  endtask

  task automatic drive(input bit st, input bit br, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
    stall = st; br_taken = br; br_target = bt; jmp = j; jmp_target = jt;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    m1 = mnext(m1, 1);
    m4 = mnext(m4, 4);
    #1;
    cmp(tag);
  endtask

  // Assert reset between edges, check immediately, hold across one edge
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    trap = 1'b0;
    #1;
    m1 = mreset();
    m4 = mreset();
    cmp("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp("reset_hold");
  endtask

  typedef struct {
    bit          st;
    bit          br;
    logic [31:0] bt;
    bit          j;
    logic [31:0] jt;
    logic [31:0] exp_pc;
    bit          exp_pend;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed rows (STEP=1 expectations), starting with the warm-up edge
    tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0,         1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h1,         1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h2,         1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h3,         1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h5,   32'h5,         1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   32'h5,         1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h0,   32'h5,         1'b1};
    tbl[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   32'h5,         1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h40,        1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 32'h0,   32'h40,        1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h40,        1'b0, 32'h0,   32'h40,        1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h80,  32'h40,        1'b1};
    tbl[12] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h80,        1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h200,       1'b1, 32'h100, 32'h100,       1'b0};
    tbl[14] = '{1'b1, 1'b1, 32'h300,       1'b0, 32'h0,   32'h100,       1'b1};
    tbl[15] = '{1'b0, 1'b1, 32'h200,       1'b0, 32'h0,   32'h200,       1'b0};
    tbl[16] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,   32'hFFFF_FFFF, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,   32'h0,         1'b0};

    #2;
    do_reset();
    chk("reset.pc_const", pc1, 32'h0);
    chk("reset.plus_const", plus1, 32'h1);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].st, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt);
      tick($sformatf("row%0d", i));
      chk($sformatf("row%0d.pc", i), pc1, tbl[i].exp_pc);
      chk($sformatf("row%0d.plus", i), plus1, 32'(tbl[i].exp_pc + 32'd1));
      chkb($sformatf("row%0d.pend", i), p1, tbl[i].exp_pend);
      chkb($sformatf("row%0d.valid", i), v1, 1'b1);
    end

    // STEP=4 wrap from the last word
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tick("wrap4a");
    chk("wrap4.pc", pc4, 32'hFFFF_FFFC);
    chk("wrap4.plus", plus4, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick("wrap4b");
    chk("wrap4.pc_after", pc4, 32'h0);

    // Redirect during the warm-up cycle is buffered, not taken
    do_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h20);
    tick("warm");
    chk("warm.pc", pc1, 32'h0);
    chkb("warm.pend", p1, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick("warm2");
    chk("warm2.pc", pc1, 32'h20);

    // Asynchronous reset mid-stall with a redirect pending
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h55);
    tick("ar1");
    drive(1'b1, 1'b1, 32'h99, 1'b0, 32'h0);
    tick("ar2");
    chk("ar.pc_before", pc1, 32'h55);
    chkb("ar.pend_before", p1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.pc", pc1, 32'h0);
    chkb("ar.pend", p1, 1'b0);
    chkb("ar.valid", v1, 1'b0);
    do_reset();

`ifdef PC_UNIT_TRAP_EN
    // Trap overrides stall
    tick("trap0");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h10);
    tick("trap1");
    drive(1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    trap = 1'b1;
    tick("trap2");
    trap = 1'b0;
    chk("trap.pc", pc1, 32'h8);
    chk("trap.epc", epc1, 32'h10);
    chkb("trap.pend", p1, 1'b0);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(59) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(2) == 0, $urandom_range(3) == 0,
              ($urandom_range(7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(3)) : $urandom,
              $urandom_range(4) == 0, $urandom);
`ifdef PC_UNIT_TRAP_EN
        trap = ($urandom_range(29) == 0);
`endif
        tick("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
